// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I-subset multi-cycle control unit.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_EXEC,
    S_R_WB,
    S_BRANCH,
    S_TRAP,
    S_ERROR
  } ctrl_state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles and flags when the configured limit is reached.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TMR_W          = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic timeout
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)         cnt_d = '0;
    else if (count_en) cnt_d = cnt_q + TMR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // A limit of zero disables the timeout entirely.
  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == TMR_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects, enables and alu_op.
module main_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TMR_W          = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       illegal_instr,
  output logic       bus_error
);

  ctrl_state_e state_q, state_d;
  logic        wait_state;
  logic        timeout;

  assign wait_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

  // Any state change clears the counter, which covers entry into every wait state.
  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TMR_W         (TMR_W)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_d != state_q),
    .count_en(wait_state && !mem_ready),
    .timeout (timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    pc_en         = 1'b0;
    pc_source     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RS2;
    alu_op        = ALU_OP_ADD;
    instr_done    = 1'b0;
    illegal_instr = 1'b0;
    bus_error     = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_FOUR;
        alu_op    = ALU_OP_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_en    = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout) begin
          state_d = S_ERROR;
        end
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
        unique case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready)    state_d = S_MEM_WB;
        else if (timeout) state_d = S_ERROR;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (timeout) begin
          state_d = S_ERROR;
        end
      end
      S_EXEC: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        alu_op    = ALU_OP_FUNCT;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_OP_FUNCT;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_OP_SUB;
        pc_source  = 1'b1;
        pc_en      = zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP:  illegal_instr = 1'b1;
      S_ERROR: bus_error     = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed-vector bench for main_control_fsm with a queue-based scoreboard.
module tb_main_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_en, pc_source, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_write, mem_to_reg, instr_done, illegal_instr, bus_error;
  logic [1:0] alu_src_a, alu_src_b, alu_op;

  always #5 clk = ~clk;

  main_control_fsm #(
    .TIMEOUT_CYCLES(4),
    .TMR_W         (5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .pc_en        (pc_en),
    .pc_source    (pc_source),
    .i_or_d       (i_or_d),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .ir_write     (ir_write),
    .reg_write    (reg_write),
    .mem_to_reg   (mem_to_reg),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .instr_done   (instr_done),
    .illegal_instr(illegal_instr),
    .bus_error    (bus_error)
  );

  // {pc_en,pc_source,i_or_d,mem_read,mem_write,ir_write,reg_write,mem_to_reg,
  //  alu_src_a,alu_src_b,alu_op,instr_done,illegal_instr,bus_error}
  logic [16:0] act;
  assign act = {pc_en, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write,
                mem_to_reg, alu_src_a, alu_src_b, alu_op, instr_done, illegal_instr, bus_error};

  localparam logic [16:0] E_IDLE      = 17'b0_0_0_0_0_0_0_0_00_00_00_0_0_0;
  localparam logic [16:0] E_FETCH     = 17'b0_0_0_1_0_0_0_0_00_01_00_0_0_0;
  localparam logic [16:0] E_FETCH_RDY = 17'b1_0_0_1_0_1_0_0_00_01_00_0_0_0;
  localparam logic [16:0] E_DECODE    = 17'b0_0_0_0_0_0_0_0_01_10_00_0_0_0;
  localparam logic [16:0] E_MEM_ADDR  = 17'b0_0_0_0_0_0_0_0_10_10_00_0_0_0;
  localparam logic [16:0] E_MEM_RD    = 17'b0_0_1_1_0_0_0_0_00_00_00_0_0_0;
  localparam logic [16:0] E_MEM_WB    = 17'b0_0_0_0_0_0_1_1_00_00_00_1_0_0;
  localparam logic [16:0] E_MEM_WR    = 17'b0_0_1_0_1_0_0_0_00_00_00_0_0_0;
  localparam logic [16:0] E_MEM_WR_OK = 17'b0_0_1_0_1_0_0_0_00_00_00_1_0_0;
  localparam logic [16:0] E_EXEC      = 17'b0_0_0_0_0_0_0_0_10_00_10_0_0_0;
  localparam logic [16:0] E_R_WB      = 17'b0_0_0_0_0_0_1_0_10_00_10_1_0_0;
  localparam logic [16:0] E_BR_TAKEN  = 17'b1_1_0_0_0_0_0_0_10_00_01_1_0_0;
  localparam logic [16:0] E_BR_NOT    = 17'b0_1_0_0_0_0_0_0_10_00_01_1_0_0;
  localparam logic [16:0] E_TRAP      = 17'b0_0_0_0_0_0_0_0_00_00_00_0_1_0;
  localparam logic [16:0] E_ERROR     = 17'b0_0_0_0_0_0_0_0_00_00_00_0_0_1;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;
  localparam logic [6:0] OPC_BAD = 7'b0010011;

  typedef struct {
    logic [16:0] v;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  // One call per clock cycle: drives that cycle's inputs and queues its expected outputs.
  task automatic cyc(input logic r, input logic rdy, input logic z, input logic [6:0] op,
                     input logic [16:0] e, input string n);
    exp_t x;
    @(negedge clk);
    #1;
    reset     = r;
    mem_ready = rdy;
    zero      = z;
    opcode    = op;
    x.v       = e;
    x.name    = n;
    sb.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        n_total++;
        if (act === x.v) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", x.name, act, x.v, $time);
      end
    end
  end

  initial begin : driver
    // Reset held for two edges.
    cyc(1, 0, 0, 7'd0, E_IDLE, "reset_idle0");
    cyc(0, 0, 0, 7'd0, E_IDLE, "reset_idle1");

    // R-type with memory always ready.
    cyc(0, 1, 0, OPC_R, E_FETCH_RDY, "r_fetch");
    cyc(0, 1, 0, OPC_R, E_DECODE,    "r_decode");
    cyc(0, 1, 0, OPC_R, E_EXEC,      "r_exec");
    cyc(0, 1, 0, OPC_R, E_R_WB,      "r_wb");

    // lw with three wait cycles in MEM_RD.
    cyc(0, 1, 0, OPC_LW, E_FETCH_RDY, "lw_fetch");
    cyc(0, 1, 0, OPC_LW, E_DECODE,    "lw_decode");
    cyc(0, 1, 0, OPC_LW, E_MEM_ADDR,  "lw_addr");
    for (int unsigned i = 0; i < 3; i++) cyc(0, 0, 0, OPC_LW, E_MEM_RD, "lw_rd_wait");
    cyc(0, 1, 0, OPC_LW, E_MEM_RD, "lw_rd_done");
    cyc(0, 1, 0, OPC_LW, E_MEM_WB, "lw_wb");

    // sw with one wait cycle.
    cyc(0, 1, 0, OPC_SW, E_FETCH_RDY, "sw_fetch");
    cyc(0, 1, 0, OPC_SW, E_DECODE,    "sw_decode");
    cyc(0, 1, 0, OPC_SW, E_MEM_ADDR,  "sw_addr");
    cyc(0, 0, 0, OPC_SW, E_MEM_WR,    "sw_wr_wait");
    cyc(0, 1, 0, OPC_SW, E_MEM_WR_OK, "sw_wr_done");

    // beq taken; fetch stalls up to the limit and ready on the limit cycle wins.
    for (int unsigned i = 0; i < 4; i++) cyc(0, 0, 1, OPC_BEQ, E_FETCH, "beq_fetch_wait");
    cyc(0, 1, 1, OPC_BEQ, E_FETCH_RDY, "beq_fetch_at_limit");
    cyc(0, 1, 1, OPC_BEQ, E_DECODE,    "beq_decode");
    cyc(0, 1, 1, OPC_BEQ, E_BR_TAKEN,  "beq_taken");

    // beq not taken.
    cyc(0, 1, 0, OPC_BEQ, E_FETCH_RDY, "beqn_fetch");
    cyc(0, 1, 0, OPC_BEQ, E_DECODE,    "beqn_decode");
    cyc(0, 1, 0, OPC_BEQ, E_BR_NOT,    "beq_not_taken");

    // Reset asserted mid-write.
    cyc(0, 1, 0, OPC_SW, E_FETCH_RDY, "rst_sw_fetch");
    cyc(0, 1, 0, OPC_SW, E_DECODE,    "rst_sw_decode");
    cyc(0, 1, 0, OPC_SW, E_MEM_ADDR,  "rst_sw_addr");
    cyc(1, 0, 0, OPC_SW, E_MEM_WR,    "rst_sw_wr");
    cyc(0, 1, 0, OPC_SW, E_IDLE,      "rst_sw_idle");

    // Fetch timeout: limit reached with mem_ready low leads to sticky ERROR.
    for (int unsigned i = 0; i < 5; i++) cyc(0, 0, 0, OPC_R, E_FETCH, "to_fetch_wait");
    for (int unsigned i = 0; i < 3; i++) cyc(0, 1, 1, OPC_R, E_ERROR, "to_error_sticky");
    cyc(1, 1, 0, OPC_R, E_ERROR, "to_error_reset");
    cyc(0, 1, 0, OPC_R, E_IDLE,  "to_idle");

    // Unsupported opcode traps until reset.
    cyc(0, 1, 0, OPC_BAD, E_FETCH_RDY, "trap_fetch");
    cyc(0, 1, 0, OPC_BAD, E_DECODE,    "trap_decode");
    for (int unsigned i = 0; i < 20; i++) cyc(0, i[0], 0, OPC_R, E_TRAP, "trap_sticky");
    cyc(1, 1, 0, OPC_R, E_TRAP, "trap_reset");
    cyc(0, 1, 0, OPC_R, E_IDLE, "trap_idle");
    cyc(0, 0, 0, OPC_R, E_FETCH, "trap_refetch");

    repeat (3) @(negedge clk);
    #5;
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule
